// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port arbiter: pipeline writeback has fixed priority, multi-cycle
// results queue in a 2-entry buffer, and a per-register scoreboard flags pending writes.
module regfile_wb_ctrl #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        p_we,
    input  logic [4:0]  p_wn,
    input  logic [31:0] p_d,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [4:0]  m_wn,
    input  logic [31:0] m_d,
    input  logic        mark_en,
    input  logic [4:0]  mark_rn,
    input  logic [4:0]  rna,
    input  logic [4:0]  rnb,
    input  logic [4:0]  rnd,
    output logic        hazard,
    output logic        hold,
    output logic        mark_err,
    output logic        we,
    output logic [4:0]  wn,
    output logic [31:0] d
);

    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
    localparam logic [3:0] WAIT_MAX = 4'hF;

    logic [4:0]  fifo_wn_reg [2];
    logic [31:0] fifo_d_reg  [2];
    logic        rd_ptr_reg;
    logic        wr_ptr_reg;
    logic [1:0]  count_reg;
    logic [1:0]  count_next;
    logic [3:0]  wait_reg;
    logic [3:0]  wait_next;
    logic        hold_reg;
    logic        hold_next;
    logic        mark_err_reg;
    logic        mark_err_next;
    logic [31:0] busy_vec;

    logic        p_sel;
    logic        pop;
    logic        accept;
    logic        push;
    logic [4:0]  head_wn;
    logic [31:0] head_d;

    // A write to r0 is a no-op and does not claim the port.
    assign p_sel   = p_we && (p_wn != 5'd0);
    assign head_wn = fifo_wn_reg[rd_ptr_reg];
    assign head_d  = fifo_d_reg[rd_ptr_reg];
    assign pop     = !p_sel && (count_reg != 2'd0);
    assign m_ready = clrn && (count_reg < 2'd2);
    assign accept  = m_valid && m_ready;
    assign push    = accept && (m_wn != 5'd0);

    always_comb begin
        we = 1'b0;
        wn = 5'd0;
        d  = 32'd0;
        if (!clrn) begin
            we = 1'b0;
        end else if (p_sel) begin
            we = 1'b1;
            wn = p_wn;
            d  = p_d;
        end else if (count_reg != 2'd0) begin
            we = 1'b1;
            wn = head_wn;
            d  = head_d;
        end
    end

    // Buffer payload needs no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wn_reg[wr_ptr_reg] <= m_wn;
            fifo_d_reg[wr_ptr_reg]  <= m_d;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_next;
        end
    end

    // Scoreboard: a mark wins over a same-cycle clear because it belongs to the newer op.
    assign busy_vec[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_busy
            logic bit_reg;
            logic set_bit;
            logic clr_bit;

            assign set_bit = mark_en && (mark_rn == 5'(gi));
            assign clr_bit = pop && (head_wn == 5'(gi));

            always_ff @(posedge clk or negedge clrn) begin
                if (!clrn) begin
                    bit_reg <= 1'b0;
                end else if (set_bit) begin
                    bit_reg <= 1'b1;
                end else if (clr_bit) begin
                    bit_reg <= 1'b0;
                end
            end

            assign busy_vec[gi] = bit_reg;
        end
    endgenerate

    assign hazard = clrn && (busy_vec[rna] || busy_vec[rnb] || busy_vec[rnd]);

    always_comb begin
        mark_err_next = mark_err_reg;
        if (mark_en && (mark_rn != 5'd0) && busy_vec[mark_rn]
                && !(pop && (head_wn == mark_rn))) begin
            mark_err_next = 1'b1;
        end
    end

    // With entries buffered and no pop, the only reason is that P held the port.
    always_comb begin
        wait_next = wait_reg;
        hold_next = hold_reg;
        if (pop || (count_reg == 2'd0)) begin
            wait_next = 4'd0;
        end else if (wait_reg != WAIT_MAX) begin
            wait_next = wait_reg + 4'd1;
        end
        if (pop) begin
            hold_next = 1'b0;
        end else if (wait_next >= LIMIT) begin
            hold_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wait_reg     <= 4'd0;
            hold_reg     <= 1'b0;
            mark_err_reg <= 1'b0;
        end else begin
            wait_reg     <= wait_next;
            hold_reg     <= hold_next;
            mark_err_reg <= mark_err_next;
        end
    end

    assign hold     = hold_reg;
    assign mark_err = mark_err_reg;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl; expected values are hand-computed per cycle.
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        clrn;
    logic        p_we;
    logic [4:0]  p_wn;
    logic [31:0] p_d;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_wn;
    logic [31:0] m_d;
    logic        mark_en;
    logic [4:0]  mark_rn;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic [4:0]  rnd;
    logic        hazard;
    logic        hold;
    logic        mark_err;
    logic        we;
    logic [4:0]  wn;
    logic [31:0] d;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb_ctrl #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .clrn(clrn),
        .p_we(p_we), .p_wn(p_wn), .p_d(p_d),
        .m_valid(m_valid), .m_ready(m_ready), .m_wn(m_wn), .m_d(m_d),
        .mark_en(mark_en), .mark_rn(mark_rn),
        .rna(rna), .rnb(rnb), .rnd(rnd),
        .hazard(hazard), .hold(hold), .mark_err(mark_err),
        .we(we), .wn(wn), .d(d)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic idle();
        p_we = 1'b0; p_wn = 5'd0; p_d = 32'd0;
        m_valid = 1'b0; m_wn = 5'd0; m_d = 32'd0;
        mark_en = 1'b0; mark_rn = 5'd0;
        rna = 5'd0; rnb = 5'd0; rnd = 5'd0;
    endtask

    // Advance past the next rising edge; inputs then change at edge+1, checks at edge+2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clrn = 1'b0;
        idle();
        // Reset forces outputs even with a live P request
        p_we = 1'b1; p_wn = 5'd3; p_d = 32'h1234_5678;
        #1;
        check_val("rst_we", we, 0);
        check_val("rst_wn", wn, 0);
        check_val("rst_m_ready", m_ready, 0);
        check_val("rst_hazard", hazard, 0);
        tick(); tick();
        check_val("rst_we_clk", we, 0);
        idle();
        clrn = 1'b1;
        #1;
        check_val("rel_m_ready", m_ready, 1);
        check_val("rel_hazard", hazard, 0);
        check_val("rel_hold", hold, 0);
        check_val("rel_mark_err", mark_err, 0);
        check_val("rel_we", we, 0);

        // M write with scoreboard
        tick();
        mark_en = 1'b1; mark_rn = 5'd5;
        tick();
        mark_en = 1'b0; m_valid = 1'b1; m_wn = 5'd5; m_d = 32'hDEAD_BEEF; rna = 5'd5;
        #1;
        check_val("mw_hazard_c1", hazard, 1);
        check_val("mw_no_bypass", we, 0);
        tick();
        m_valid = 1'b0;
        #1;
        check_val("mw_hazard_c2", hazard, 1);
        check_val("mw_we", we, 1);
        check_val("mw_wn", wn, 5);
        check_val("mw_d", d, 32'hDEAD_BEEF);
        tick();
        #1;
        check_val("mw_hazard_clr", hazard, 0);
        check_val("mw_we_idle", we, 0);
        rnb = 5'd5; rnd = 5'd5;
        #1;
        check_val("mw_hazard_bd", hazard, 0);
        idle();

        // Conflict: P wins, buffered r7 follows
        m_valid = 1'b1; m_wn = 5'd7; m_d = 32'h0000_0077;
        tick();
        m_valid = 1'b0; p_we = 1'b1; p_wn = 5'd9; p_d = 32'h0000_0099;
        #1;
        check_val("cf_p_wn", wn, 9);
        check_val("cf_p_d", d, 32'h99);
        tick();
        p_we = 1'b0;
        #1;
        check_val("cf_m_we", we, 1);
        check_val("cf_m_wn", wn, 7);
        check_val("cf_m_d", d, 32'h77);
        tick();
        #1;
        check_val("cf_popped", we, 0);

        // p_we to r0 leaves the port to M
        m_valid = 1'b1; m_wn = 5'd14; m_d = 32'h0000_00E1;
        tick();
        m_valid = 1'b0; p_we = 1'b1; p_wn = 5'd0; p_d = 32'hFFFF_FFFF;
        #1;
        check_val("r0_we", we, 1);
        check_val("r0_wn", wn, 14);
        check_val("r0_d", d, 32'hE1);
        tick();
        idle();
        #1;
        check_val("r0_popped", we, 0);

        // Full / backpressure with P busy
        p_we = 1'b1; p_wn = 5'd10; p_d = 32'hA0;
        m_valid = 1'b1; m_wn = 5'd11; m_d = 32'hB1;
        #1;
        check_val("bp_ready0", m_ready, 1);
        tick();
        m_wn = 5'd12; m_d = 32'hC1;
        #1;
        check_val("bp_ready1", m_ready, 1);
        check_val("bp_p_wn", wn, 10);
        tick();
        m_wn = 5'd13; m_d = 32'hD1;
        #1;
        check_val("bp_full", m_ready, 0);
        check_val("bp_p_wins", wn, 10);
        tick();
        p_we = 1'b0;
        #1;
        check_val("bp_full_pop_ready", m_ready, 0);
        check_val("bp_pop11_wn", wn, 11);
        check_val("bp_pop11_d", d, 32'hB1);
        tick();
        #1;
        check_val("bp_ready_again", m_ready, 1);
        check_val("bp_pop12_wn", wn, 12);
        check_val("bp_pop12_d", d, 32'hC1);
        tick();
        m_valid = 1'b0;
        #1;
        check_val("bp_pop13_wn", wn, 13);
        check_val("bp_pop13_d", d, 32'hD1);
        check_val("bp_hold", hold, 0);
        tick();
        #1;
        check_val("bp_empty", we, 0);

        // Starvation with STARVE_LIMIT = 4
        m_valid = 1'b1; m_wn = 5'd8; m_d = 32'h88;
        tick();
        m_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            p_we = 1'b1; p_wn = 5'(i); p_d = 32'(i);
            #1;
            check_val($sformatf("st_hold_low_%0d", i), hold, 0);
            check_val($sformatf("st_p_wn_%0d", i), wn, 32'(i));
            tick();
        end
        p_wn = 5'd5; p_d = 32'h5;
        #1;
        check_val("st_hold_set", hold, 1);
        check_val("st_advisory_wn", wn, 5);
        tick();
        p_we = 1'b0;
        #1;
        check_val("st_hold_still", hold, 1);
        check_val("st_m_wn", wn, 8);
        check_val("st_m_d", d, 32'h88);
        tick();
        #1;
        check_val("st_hold_clr", hold, 0);
        check_val("st_empty", we, 0);

        // M result to r0 is accepted but never written
        m_valid = 1'b1; m_wn = 5'd0; m_d = 32'h123;
        #1;
        check_val("z_ready", m_ready, 1);
        tick();
        m_valid = 1'b0;
        #1;
        check_val("z_no_write", we, 0);
        check_val("z_ready_after", m_ready, 1);

        // Double mark -> sticky mark_err
        mark_en = 1'b1; mark_rn = 5'd6;
        tick();
        #1;
        check_val("dm_err_first", mark_err, 0);
        tick();
        mark_en = 1'b0; rna = 5'd6;
        #1;
        check_val("dm_err_set", mark_err, 1);
        check_val("dm_hazard", hazard, 1);
        tick();
        #1;
        check_val("dm_err_sticky", mark_err, 1);

        // Mark and pop of r6 in the same cycle keep busy set
        m_valid = 1'b1; m_wn = 5'd6; m_d = 32'h66;
        tick();
        m_valid = 1'b0; mark_en = 1'b1; mark_rn = 5'd6;
        #1;
        check_val("mp_wn", wn, 6);
        tick();
        mark_en = 1'b0;
        #1;
        check_val("mp_busy_kept", hazard, 1);
        m_valid = 1'b1; m_wn = 5'd6; m_d = 32'h67;
        tick();
        m_valid = 1'b0;
        #1;
        check_val("mp_second_wn", wn, 6);
        tick();
        #1;
        check_val("mp_busy_clr", hazard, 0);

        // Reset mid-operation discards buffered result
        m_valid = 1'b1; m_wn = 5'd20; m_d = 32'h2020;
        mark_en = 1'b1; mark_rn = 5'd20;
        tick();
        idle();
        clrn = 1'b0;
        rna = 5'd20;
        #1;
        check_val("mr_we", we, 0);
        check_val("mr_ready", m_ready, 0);
        check_val("mr_hazard", hazard, 0);
        check_val("mr_mark_err", mark_err, 0);
        tick();
        clrn = 1'b1;
        #1;
        check_val("mr_we_after", we, 0);
        check_val("mr_hazard_after", hazard, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
